// File: rtl/rx_frame_ctrl_if.sv
// rx_frame_ctrl_if: byte-stream, frame-handshake and status bundle for rx_frame_ctrl.
//   byte_i/byte_vld_i      received byte and its one-cycle strobe
//   ack_i/frame_vld_o      frame handshake, cmd_o/len_o describe the held frame
//   rd_addr_i/rd_data_o    combinational payload read port
//   busy_o, err_o, err_code_o  reception status and error reporting
interface rx_frame_ctrl_if;
    logic [7:0] byte_i;
    logic       byte_vld_i;
    logic       ack_i;
    logic       frame_vld_o;
    logic [7:0] cmd_o;
    logic [3:0] len_o;
    logic [3:0] rd_addr_i;
    logic [7:0] rd_data_o;
    logic       busy_o;
    logic       err_o;
    logic [1:0] err_code_o;
    modport master (
        output byte_i, byte_vld_i, ack_i, rd_addr_i,
        input  frame_vld_o, cmd_o, len_o, rd_data_o, busy_o, err_o, err_code_o
    );
    modport slave (
        input  byte_i, byte_vld_i, ack_i, rd_addr_i,
        output frame_vld_o, cmd_o, len_o, rd_data_o, busy_o, err_o, err_code_o
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: parses SYNC/CMD/LEN/payload/CHK frames from a byte receiver with inter-byte timeout.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   bus (slave)    byte input, validated-frame handshake, payload read port, busy/error status
module rx_frame_ctrl #(
    parameter int unsigned MAX_LEN     = 8,
    parameter logic [7:0]  SYNC        = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input logic           clk_i,
    input logic           rst_i,
    rx_frame_ctrl_if.slave bus
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]    state_q;
    logic [7:0]    cmd_sh_q, cmd_q, chk_q;
    logic [3:0]    len_sh_q, len_q, idx_q;
    logic [TW-1:0] tmo_q;
    logic          frame_vld_q, err_q;
    logic [1:0]    err_code_q;
    logic [7:0]    buf_q [0:(1<<AW)-1];
    logic          busy, vld;

    assign vld  = bus.byte_vld_i;
    assign busy = (state_q == S_CMD) || (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CHK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cmd_sh_q    <= 8'h00;
            cmd_q       <= 8'h00;
            chk_q       <= 8'h00;
            len_sh_q    <= 4'd0;
            len_q       <= 4'd0;
            idx_q       <= 4'd0;
            tmo_q       <= '0;
            frame_vld_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            err_q <= 1'b0;
            // Any accepted byte below overrides this and restarts the inter-byte window.
            tmo_q <= busy ? tmo_q + TW'(1) : '0;
            case (state_q)
                S_IDLE: if (vld && bus.byte_i == SYNC) state_q <= S_CMD;
                S_CMD: if (vld) begin
                    tmo_q    <= '0;
                    cmd_sh_q <= bus.byte_i;
                    chk_q    <= bus.byte_i;
                    state_q  <= S_LEN;
                end
                S_LEN: if (vld) begin
                    tmo_q <= '0;
                    if (bus.byte_i > 8'(MAX_LEN)) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                        state_q    <= S_IDLE;
                    end else begin
                        len_sh_q <= bus.byte_i[3:0];
                        chk_q    <= chk_q ^ bus.byte_i;
                        idx_q    <= 4'd0;
                        state_q  <= (bus.byte_i == 8'h00) ? S_CHK : S_PAY;
                    end
                end
                S_PAY: if (vld) begin
                    tmo_q <= '0;
                    idx_q <= idx_q + 4'd1;
                    chk_q <= chk_q ^ bus.byte_i;
                    if (idx_q == len_sh_q - 4'd1) state_q <= S_CHK;
                end
                S_CHK: if (vld) begin
                    tmo_q <= '0;
                    if (bus.byte_i == chk_q) begin
                        cmd_q       <= cmd_sh_q;
                        len_q       <= len_sh_q;
                        frame_vld_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                        state_q    <= S_IDLE;
                    end
                end
                S_DONE: begin
                    // Bytes arriving while a frame is held are lost, even alongside the ack.
                    if (vld) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b00;
                    end
                    if (bus.ack_i) begin
                        frame_vld_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // A byte arriving on the terminal count is processed above instead of timing out.
            if (busy && !vld && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                err_q      <= 1'b1;
                err_code_q <= 2'b11;
                state_q    <= S_IDLE;
            end
        end
    end

    // Payload store has no reset; reads are masked by len_o instead.
    always_ff @(posedge clk_i) begin
        if (state_q == S_PAY && vld) buf_q[idx_q[AW-1:0]] <= bus.byte_i;
    end

    assign bus.rd_data_o   = (bus.rd_addr_i < len_q) ? buf_q[bus.rd_addr_i[AW-1:0]] : 8'h00;
    assign bus.frame_vld_o = frame_vld_q;
    assign bus.cmd_o       = cmd_q;
    assign bus.len_o       = len_q;
    assign bus.busy_o      = busy;
    assign bus.err_o       = err_q;
    assign bus.err_code_o  = err_code_q;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frame scenarios against rx_frame_ctrl with TIMEOUT_CYC=20.
module tb_rx_frame_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    rx_frame_ctrl_if bus();

    rx_frame_ctrl #(.MAX_LEN(8), .SYNC(8'hAA), .TIMEOUT_CYC(20)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic send(input logic [7:0] b);
        @(negedge clk_i);
        bus.byte_i     = b;
        bus.byte_vld_i = 1'b1;
        @(negedge clk_i);
        bus.byte_vld_i = 1'b0;
    endtask

    task automatic ack_frame();
        @(negedge clk_i);
        bus.ack_i = 1'b1;
        @(negedge clk_i);
        bus.ack_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        n_cmp++; if (bus.frame_vld_o !== 1'b0) begin n_bad++; $display("FAIL rst_vld got %b exp 0", bus.frame_vld_o); end
        n_cmp++; if (bus.cmd_o !== 8'h00) begin n_bad++; $display("FAIL rst_cmd got %h exp 00", bus.cmd_o); end
        n_cmp++; if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy_err got %b%b exp 00", bus.busy_o, bus.err_o); end
        n_cmp++; if (bus.err_code_o !== 2'b00 || bus.len_o !== 4'd0) begin n_bad++; $display("FAIL rst_code_len got %b/%0d exp 00/0", bus.err_code_o, bus.len_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_rd [4] = '{8'h01, 8'h02, 8'h03, 8'h00};
        send(8'hAA); send(8'h10); send(8'h03); send(8'h01); send(8'h02);
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL good_busy got %b exp 1", bus.busy_o); end
        send(8'h03);
        n_cmp++; if (bus.frame_vld_o !== 1'b0) begin n_bad++; $display("FAIL good_vld_early got %b exp 0", bus.frame_vld_o); end
        send(8'h13);
        n_cmp++; if (bus.frame_vld_o !== 1'b1) begin n_bad++; $display("FAIL good_vld got %b exp 1", bus.frame_vld_o); end
        n_cmp++; if (bus.cmd_o !== 8'h10 || bus.len_o !== 4'd3) begin n_bad++; $display("FAIL good_cmd_len got %h/%0d exp 10/3", bus.cmd_o, bus.len_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL good_busy_done got %b exp 0", bus.busy_o); end
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr_i = 4'(i);
            #1;
            n_cmp++; if (bus.rd_data_o !== exp_rd[i]) begin n_bad++; $display("FAIL good_rd%0d got %h exp %h", i, bus.rd_data_o, exp_rd[i]); end
        end
        ack_frame();
        n_cmp++; if (bus.frame_vld_o !== 1'b0) begin n_bad++; $display("FAIL good_ack got %b exp 0", bus.frame_vld_o); end
    endtask

    task automatic test_zero_len();
        send(8'h00);
        n_cmp++; if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL junk00 got err %b busy %b exp 0 0", bus.err_o, bus.busy_o); end
        send(8'hFF);
        n_cmp++; if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL junkFF got err %b busy %b exp 0 0", bus.err_o, bus.busy_o); end
        send(8'hAA); send(8'h55); send(8'h00); send(8'h55);
        n_cmp++; if (bus.frame_vld_o !== 1'b1) begin n_bad++; $display("FAIL zl_vld got %b exp 1", bus.frame_vld_o); end
        n_cmp++; if (bus.cmd_o !== 8'h55 || bus.len_o !== 4'd0) begin n_bad++; $display("FAIL zl_cmd_len got %h/%0d exp 55/0", bus.cmd_o, bus.len_o); end
        bus.rd_addr_i = 4'd0;
        #1;
        n_cmp++; if (bus.rd_data_o !== 8'h00) begin n_bad++; $display("FAIL zl_rd0 got %h exp 00", bus.rd_data_o); end
    endtask

    task automatic test_overrun();
        send(8'h33);
        n_cmp++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'b00) begin n_bad++; $display("FAIL ovr_err got %b/%b exp 1/00", bus.err_o, bus.err_code_o); end
        n_cmp++; if (bus.frame_vld_o !== 1'b1) begin n_bad++; $display("FAIL ovr_hold got %b exp 1", bus.frame_vld_o); end
        @(negedge clk_i);
        n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL ovr_strobe got %b exp 0", bus.err_o); end
        bus.ack_i      = 1'b1;
        bus.byte_vld_i = 1'b1;
        bus.byte_i     = 8'hAA;
        @(negedge clk_i);
        bus.ack_i      = 1'b0;
        bus.byte_vld_i = 1'b0;
        n_cmp++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'b00) begin n_bad++; $display("FAIL ovr_ack_err got %b/%b exp 1/00", bus.err_o, bus.err_code_o); end
        n_cmp++; if (bus.frame_vld_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL ovr_ack_idle got vld %b busy %b exp 0 0", bus.frame_vld_o, bus.busy_o); end
    endtask

    task automatic test_bad_chk();
        send(8'hAA);
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL bchk_sync got %b exp 1", bus.busy_o); end
        send(8'h10); send(8'h01); send(8'h07); send(8'h00);
        n_cmp++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'b10) begin n_bad++; $display("FAIL bchk_err got %b/%b exp 1/10", bus.err_o, bus.err_code_o); end
        n_cmp++; if (bus.frame_vld_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL bchk_state got vld %b busy %b exp 0 0", bus.frame_vld_o, bus.busy_o); end
        n_cmp++; if (bus.cmd_o !== 8'h55 || bus.len_o !== 4'd0) begin n_bad++; $display("FAIL bchk_keep got %h/%0d exp 55/0", bus.cmd_o, bus.len_o); end
        @(negedge clk_i);
        n_cmp++; if (bus.err_o !== 1'b0 || bus.err_code_o !== 2'b10) begin n_bad++; $display("FAIL bchk_strobe got %b/%b exp 0/10", bus.err_o, bus.err_code_o); end
    endtask

    task automatic test_bad_len();
        send(8'hAA); send(8'h10); send(8'h09);
        n_cmp++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'b01) begin n_bad++; $display("FAIL blen_err got %b/%b exp 1/01", bus.err_o, bus.err_code_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL blen_busy got %b exp 0", bus.busy_o); end
        send(8'hAA); send(8'h20); send(8'h01); send(8'h5A); send(8'h7B);
        n_cmp++; if (bus.frame_vld_o !== 1'b1 || bus.cmd_o !== 8'h20 || bus.len_o !== 4'd1) begin n_bad++; $display("FAIL blen_next got %b/%h/%0d exp 1/20/1", bus.frame_vld_o, bus.cmd_o, bus.len_o); end
        bus.rd_addr_i = 4'd0;
        #1;
        n_cmp++; if (bus.rd_data_o !== 8'h5A) begin n_bad++; $display("FAIL blen_rd0 got %h exp 5a", bus.rd_data_o); end
        bus.rd_addr_i = 4'd1;
        #1;
        n_cmp++; if (bus.rd_data_o !== 8'h00) begin n_bad++; $display("FAIL blen_rd1 got %h exp 00", bus.rd_data_o); end
        ack_frame();
    endtask

    task automatic test_timeout();
        send(8'hAA); send(8'h10);
        repeat (19) @(negedge clk_i);
        n_cmp++; if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL tmo_early got err %b busy %b exp 0 1", bus.err_o, bus.busy_o); end
        @(negedge clk_i);
        n_cmp++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'b11) begin n_bad++; $display("FAIL tmo_err got %b/%b exp 1/11", bus.err_o, bus.err_code_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL tmo_idle got %b exp 0", bus.busy_o); end
    endtask

    task automatic test_timeout_edge();
        send(8'hAA); send(8'h10);
        repeat (18) @(negedge clk_i);
        send(8'h02);
        n_cmp++; if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL tedge got err %b busy %b exp 0 1", bus.err_o, bus.busy_o); end
        @(negedge clk_i);
        n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL tedge_after got %b exp 0", bus.err_o); end
        send(8'h01); send(8'h02); send(8'h11);
        n_cmp++; if (bus.frame_vld_o !== 1'b1 || bus.len_o !== 4'd2) begin n_bad++; $display("FAIL tedge_frame got %b/%0d exp 1/2", bus.frame_vld_o, bus.len_o); end
        bus.rd_addr_i = 4'd1;
        #1;
        n_cmp++; if (bus.rd_data_o !== 8'h02) begin n_bad++; $display("FAIL tedge_rd1 got %h exp 02", bus.rd_data_o); end
        ack_frame();
    endtask

    task automatic test_reset_mid();
        send(8'hAA); send(8'h10); send(8'h03); send(8'h01);
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL rmid_busy got %b exp 1", bus.busy_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        bus.rd_addr_i = 4'd0;
        n_cmp++; if (bus.busy_o !== 1'b0 || bus.frame_vld_o !== 1'b0 || bus.err_o !== 1'b0) begin n_bad++; $display("FAIL rmid_flags got busy %b vld %b err %b exp 0 0 0", bus.busy_o, bus.frame_vld_o, bus.err_o); end
        n_cmp++; if (bus.cmd_o !== 8'h00 || bus.len_o !== 4'd0 || bus.err_code_o !== 2'b00) begin n_bad++; $display("FAIL rmid_regs got %h/%0d/%b exp 00/0/00", bus.cmd_o, bus.len_o, bus.err_code_o); end
        #1;
        n_cmp++; if (bus.rd_data_o !== 8'h00) begin n_bad++; $display("FAIL rmid_rd got %h exp 00", bus.rd_data_o); end
        @(negedge clk_i);
        n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL rmid_err got %b exp 0", bus.err_o); end
        rst_i = 1'b0;
    endtask

    initial begin
        bus.byte_i     = 8'h00;
        bus.byte_vld_i = 1'b0;
        bus.ack_i      = 1'b0;
        bus.rd_addr_i  = 4'd0;
        test_reset();
        test_good_frame();
        test_zero_len();
        test_overrun();
        test_bad_chk();
        test_bad_len();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Command-frame controller sitting directly behind the RS-232 byte receiver. It consumes one received byte per strobe, tracks the frame protocol (sync, command, length, payload, checksum) and enforces an inter-byte timeout. Payload bytes are buffered internally, and a validated command is presented to the register/configuration logic with a valid/ack handshake. Malformed or late frames are discarded and reported through a one-cycle error strobe plus a held error code.

## Interface
- MAX_LEN, 8: maximum payload bytes per frame (1..15); sets buffer depth.
- SYNC, 8'hAA: frame start byte.
- TIMEOUT_CYC, 50000: clk_i cycles allowed between consecutive bytes inside a frame (≥2).
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- byte_i  in  8  received byte; valid only when byte_vld_i=1.
- byte_vld_i  in  1  one-cycle strobe from receiver, byte complete.
- ack_i  in  1  consumer accepts the presented frame.
- frame_vld_o  out  1  validated frame available; held until ack_i.
- cmd_o  out  8  command byte of the presented frame.
- len_o  out  4  payload length of the presented frame.
- rd_addr_i  in  4  payload read index.
- rd_data_o  out  8  payload byte at rd_addr_i (combinational read).
- busy_o  out  1  frame reception in progress (state not IDLE/DONE).
- err_o  out  1  one-cycle error strobe.
- err_code_o  out  2  last error: 00 overrun, 01 bad length, 10 checksum, 11 timeout.

## Operation
- Frame on the wire: SYNC, CMD, LEN, LEN payload bytes, CHK. CHK = CMD ^ LEN ^ all payload bytes (8-bit XOR).
- States: IDLE, CMD, LEN, PAY, CHK, DONE. All transitions are taken on a clock edge where byte_vld_i=1, except timeout and ack.
- IDLE: byte==SYNC → CMD. Any other byte is ignored silently.
- CMD: latch byte into the shadow command and into the running checksum → LEN.
- LEN: byte[7:0]>MAX_LEN → err 01, IDLE. byte==0 → CHK. Otherwise latch the length, clear the write index → PAY.
- PAY: write byte to buffer[idx], idx+1, XOR into the checksum. Last byte (idx==len-1) → CHK.
- CHK: byte==checksum → commit cmd_o/len_o, frame_vld_o=1 → DONE. Mismatch → err 10, IDLE. On mismatch, frame_vld_o stays 0 and cmd_o/len_o keep their old values.
- DONE: hold outputs and buffer. ack_i=1 → IDLE next cycle, frame_vld_o=0.
  - A byte strobe in DONE, including the same cycle as ack_i, is dropped and raises err 00.
- Timeout counter:
  - Cleared on every accepted byte and in IDLE/DONE.
  - Increments each cycle in CMD/LEN/PAY/CHK.
  - When it reaches TIMEOUT_CYC-1 with no byte that cycle → err 11, IDLE.
  - A byte and the terminal count in the same cycle: the byte wins and is processed.
- rd_data_o = buffer[rd_addr_i] when rd_addr_i<len_o, else 8'h00. Buffer contents are stable while frame_vld_o=1; PAY of the next frame may overwrite them.
- err_o: high exactly one cycle per error event. err_code_o updates in the same cycle and holds until the next error.

## Timing
- Reset values: state IDLE; frame_vld_o 0, cmd_o 8'h00, len_o 0, busy_o 0, err_o 0, err_code_o 00, counters and checksum 0. Buffer contents are don't-care (rd_data_o reads 0 because len_o=0).
- Reset asserted mid-frame aborts immediately with no error strobe.
- frame_vld_o rises the cycle after the CHK byte strobe (1-cycle latency).
- frame_vld_o falls the cycle after ack_i is sampled high. ack_i while frame_vld_o=0 is ignored.
- Earliest next SYNC acceptance: the cycle after returning to IDLE.
- busy_o is registered state decode: 1 in CMD/LEN/PAY/CHK.

## Test plan
- Good frame AA 10 03 01 02 03 13 -> frame_vld_o=1 one cycle after the last strobe; cmd_o=8'h10, len_o=3; rd_data_o at addr 0/1/2/3 = 01/02/03/00. ack_i -> frame_vld_o=0 next cycle.
- Zero-length frame AA 55 00 55, preceded by junk 00 FF -> junk ignored with no err_o; frame_vld_o=1, cmd_o=8'h55, len_o=0.
- Bad checksum AA 10 01 07 00 -> err_o one cycle with err_code_o=10; frame_vld_o stays 0; busy_o=0 afterwards.
- LEN=MAX_LEN+1 -> err_code_o=01 at the LEN byte. A following good frame is accepted normally.
- With TIMEOUT_CYC=20: AA 10 then silence -> err_code_o=11 exactly 20 cycles after the 10 strobe. A byte on the terminal cycle instead advances to PAY with no error.
- Frame pending, then a byte strobe coincident with ack_i -> err_code_o=00, state IDLE. Reset asserted mid-PAY -> all outputs at reset values, no err_o.
